// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
// Opcode encodings, FSM states and the default settle time.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_SLT;
    endfunction

endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module alu_settle_cnt
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/settle/hold sequencer wrapped around an external ALU datapath.
// Optional macro ALU_ILLEGAL_OP_CHECK_EN: reserved opcodes answer with rsp_err.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_f,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_f,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             cap;
    logic             ill;
    logic             err_pend;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;

    assign req_ready = (state == IDLE) || (state == HOLD && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == HOLD);

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign ill = op_illegal(req_op);

    // Error ops take a single settle cycle and ignore the datapath result.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) err_pend <= ill;
            if (cap)    rsp_err  <= err_pend;
        end
    end
`else
    assign ill      = 1'b0;
    assign err_pend = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    assign load_val = ill ? '0 : LOAD;

    alu_settle_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (state == SETTLE),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt_zero) begin
                    cap       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nxt = SETTLE;
                end else if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x        <= '0;
            alu_y        <= '0;
            alu_op       <= OP_ADD;
            rsp_f        <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            if (accept) begin
                alu_x  <= req_x;
                alu_y  <= req_y;
                alu_op <= req_op;
            end
            if (cap) begin
                rsp_f        <= err_pend ? '0 : alu_f;
                rsp_overflow <= alu_overflow && !err_pend;
                rsp_zero     <= alu_zero || err_pend;
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, number of clk cycles operands are held on the ALU before its outputs are sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  upstream request valid.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_x, req_y  input  32 each  operands.
REQ-007 req_op  input  3  opcode: 000 add, 001 or, 010 and, 011 sub, 100 slt, 101-111 reserved.
REQ-008 alu_x, alu_y, alu_op  output  32/32/3  registered operands and opcode driven to the alu datapath.
REQ-009 alu_f, alu_overflow, alu_zero  input  32/1/1  alu datapath result, overflow and zero flags.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  downstream accepts response.
REQ-012 rsp_f, rsp_overflow, rsp_zero, rsp_err  output  32/1/1/1  registered result, flags, illegal-op error.

Function
REQ-013 FSM SHALL have states IDLE, SETTLE, HOLD.
REQ-014 req_ready SHALL equal (state==IDLE) | (state==HOLD & rsp_ready).
REQ-015 Accept occurs on an edge where req_valid & req_ready; it SHALL load alu_x/alu_y/alu_op from req_*, load counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-016 In SETTLE, counter SHALL decrement each edge; on the edge with counter==0 the block SHALL capture alu_f/alu_overflow/alu_zero into rsp_*, set rsp_err=0, and enter HOLD.
REQ-017 Latency: accept at edge N SHALL yield rsp_valid=1 after edge N+SETTLE_CYCLES.
REQ-018 rsp_valid SHALL be 1 only in HOLD; rsp_* SHALL stay stable while rsp_valid & !rsp_ready.
REQ-019 HOLD with rsp_ready & !req_valid SHALL go to IDLE; HOLD with rsp_ready & req_valid SHALL accept the new request in the same edge (back-to-back, no IDLE bubble).
REQ-020 alu_x/alu_y/alu_op SHALL remain unchanged from accept until the next accept.
REQ-021 req_* SHALL be ignored when req_ready=0; upstream holds req_* stable until accepted.
REQ-022 Counter width SHALL be 8 bits; no wrap-around occurs since it is reloaded only on accept.

Reset
REQ-023 rst SHALL force state=IDLE, counter=0, alu_x=alu_y=0, alu_op=000, rsp_f=0, rsp_overflow=0, rsp_zero=0, rsp_err=0, rsp_valid=0.
REQ-024 rst asserted in SETTLE or HOLD SHALL abort the operation; the in-flight response is discarded, never presented.
REQ-025 rst SHALL dominate a simultaneous accept or response handshake.

Configuration
REQ-026 Macro ALU_ILLEGAL_OP_CHECK_EN defined: accept with req_op in 101..111 SHALL skip SETTLE, enter HOLD after one edge with rsp_f=0, rsp_overflow=0, rsp_zero=1, rsp_err=1; alu_* still loaded.
REQ-027 Macro undefined: reserved opcodes SHALL be handled as normal ops through SETTLE; rsp_err SHALL be tied 0.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode constants (OP_ADD..OP_SLT), FSM state typedef, and SETTLE_CYCLES default.
REQ-029 Block SHALL be FSM plus registers only; one sub-module, alu_settle_cnt (loadable down-counter with zero flag), is natural; alu datapath is instantiated at the parent level, not inside.

Verification
REQ-030 SETTLE_CYCLES=4, accept x=1024 y=128 op=000 at edge N -> rsp_valid after edge N+4, rsp_f=1152, rsp_zero=0, rsp_overflow=0.
REQ-031 x=5 y=5 op=011 -> rsp_f=0, rsp_zero=1; x=3 y=7 op=100 -> rsp_f=1.
REQ-032 rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_f stable, req_ready=0 throughout; rsp_ready=1 with req_valid=1 -> new accept same edge, rsp_valid drops next cycle.
REQ-033 rst pulsed 1 cycle at edge N+2 of an op -> rsp_valid never rises for that op, all outputs at reset values, next request completes normally.
REQ-034 ALU_ILLEGAL_OP_CHECK_EN defined, op=110 -> rsp_valid after edge N+1, rsp_err=1, rsp_f=0; undefined -> rsp_valid after edge N+4, rsp_err=0.
REQ-035 SETTLE_CYCLES=1, 8 back-to-back ops with rsp_ready=1 -> one response every 2 cycles, results in order.
